// File: rtl/axi_rd_burst_master.sv
// AXI3 read-burst master for bring-up: issues a programmed series of INCR bursts, one outstanding,
// checks RID/RRESP/RLAST and XOR-accumulates read data. Define AXI_RD_DATA_CHECK_EN for the data comparator.
module axi_rd_burst_master #(
   parameter int unsigned     ID_W     = 4,
   parameter int unsigned     ADDR_W   = 32,
   parameter int unsigned     DATA_W   = 32,
   parameter int unsigned     CNT_W    = 16,
   parameter logic [ID_W-1:0] ARID_VAL = '0
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [3:0]        cfg_len,
   input  logic [CNT_W-1:0]  cfg_num,
   input  logic [ADDR_W-1:0] cfg_stride,
   output logic              busy,
   output logic              done,
   output logic              err_resp,
   output logic              err_last,
   output logic              err_id,
   output logic              err_data,
   output logic [DATA_W-1:0] rd_sum,
   output logic [CNT_W+3:0]  beat_cnt,
   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [3:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [1:0]        arlock,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   localparam int unsigned SIZE_LG2 = $clog2(DATA_W / 8);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [ADDR_W-1:0] r_stride;
   logic [3:0]        r_len;
   logic [3:0]        r_idx;
   logic [CNT_W-1:0]  r_left;
   logic [DATA_W-1:0] r_sum;
   logic [CNT_W+3:0]  r_cnt;
   logic              r_err_resp;
   logic              r_err_last;
   logic              r_err_id;
   logic              w_beat;
   logic              w_idx_last;
   logic              w_burst_end;
   logic              w_last_burst;
   logic              w_accept;

   assign w_accept     = (r_state == S_IDLE) && start;
   assign w_beat       = (r_state == S_DATA) && rvalid;
   assign w_idx_last   = (r_idx == r_len);
   // A burst closes on whichever comes first: the beat counter or the slave's RLAST.
   assign w_burst_end  = w_beat && (w_idx_last || rlast);
   assign w_last_burst = (r_left == CNT_W'(1));

   always_ff @(posedge aclk) begin
      if (areset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (cfg_num == '0) ? S_DONE : S_ADDR;
         S_ADDR:  if (arready) w_next = S_DATA;
         S_DATA:  if (w_burst_end) w_next = w_last_burst ? S_DONE : S_ADDR;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      arvalid = 1'b0;
      rready  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (r_state)
         S_ADDR:  begin arvalid = 1'b1; busy = 1'b1; end
         S_DATA:  begin rready  = 1'b1; busy = 1'b1; end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_cur_addr <= '0;
         r_stride   <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_left     <= '0;
         r_sum      <= '0;
         r_cnt      <= '0;
         r_err_resp <= 1'b0;
         r_err_last <= 1'b0;
         r_err_id   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_cur_addr <= cfg_addr;
               r_stride   <= cfg_stride;
               r_len      <= cfg_len;
               r_left     <= cfg_num;
               r_idx      <= '0;
               r_sum      <= '0;
               r_cnt      <= '0;
               r_err_resp <= 1'b0;
               r_err_last <= 1'b0;
               r_err_id   <= 1'b0;
            end
            S_ADDR: if (arready) r_idx <= '0;
            S_DATA: if (w_beat) begin
               r_sum <= r_sum ^ rdata;
               r_cnt <= r_cnt + (CNT_W + 4)'(1);
               r_idx <= r_idx + 4'd1;
               if (rid != ARID_VAL)     r_err_id   <= 1'b1;
               if (rresp != 2'b00)      r_err_resp <= 1'b1;
               if (w_idx_last != rlast) r_err_last <= 1'b1;
               if (w_burst_end) begin
                  r_left     <= r_left - CNT_W'(1);
                  r_cur_addr <= r_cur_addr + r_stride;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef AXI_RD_DATA_CHECK_EN
   logic r_err_data;

   // Expected payload is the byte address of the beat, resized to the data bus.
   function automatic logic [DATA_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [3:0]        idx);
      logic [ADDR_W-1:0] a;
      a = base + (ADDR_W'(idx) << SIZE_LG2);
      return DATA_W'(a);
   endfunction

   always_ff @(posedge aclk) begin
      if (areset)                                                r_err_data <= 1'b0;
      else if (w_accept)                                         r_err_data <= 1'b0;
      else if (w_beat && (rdata != beat_addr(r_cur_addr, r_idx))) r_err_data <= 1'b1;
   end

   assign err_data = r_err_data;
`else
   assign err_data = 1'b0;
`endif

   assign err_resp = r_err_resp;
   assign err_last = r_err_last;
   assign err_id   = r_err_id;
   assign rd_sum   = r_sum;
   assign beat_cnt = r_cnt;
   assign araddr   = r_cur_addr;
   assign arlen    = r_len;
   assign arid     = ARID_VAL;
   assign arsize   = 3'(SIZE_LG2);
   assign arburst  = 2'b01;
   assign arlock   = 2'b00;
   assign arcache  = 4'b0000;
   assign arprot   = 3'b000;

endmodule
